// File: rtl/dat_init_seq_pkg.sv
// Shared definitions for the DAT SRAM init sequencer: FSM states, DAT port
// widths and the identity-map pattern that each task slot is filled with.
package dat_init_seq_pkg;

  localparam int DAT_ADDR_W = 15;
  localparam int DAT_DATA_W = 16;

  typedef enum logic [2:0] {
    W_SETUP  = 3'd0,
    W_STROBE = 3'd1,
    V_ADDR   = 3'd2,
    V_CMP    = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Slot s of every task maps to bank {5'b0,s}, i.e. the unmapped 64K view.
  function automatic logic [DAT_DATA_W-1:0] identity_pattern(input logic [2:0] slot);
    return {8'h00, 5'b00000, slot};
  endfunction

endpackage

// File: rtl/dat_init_seq.sv
// DAT SRAM init sequencer: fills every DAT entry with the identity map,
// optionally reads every entry back, and reports the first mismatch.
// All outputs are registered decodes of the current state/counter, so the
// DAT port lags the state register by one cycle; the reset (or start)
// cycle acts as the idle cycle in front of the first setup cycle.
module dat_init_seq
  import dat_init_seq_pkg::*;
#(
  parameter int TASK_BITS = 12,
  parameter bit VERIFY    = 1'b1
) (
  input  logic                  e,
  input  logic                  _reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DAT_ADDR_W-1:0] fail_addr,
  output logic [DAT_ADDR_W-1:0] address_dat,
  output logic [DAT_DATA_W-1:0] dat_wdata,
  output logic                  dat_oe,
  input  logic [DAT_DATA_W-1:0] dat_rdata,
  output logic                  _we_dat_l,
  output logic                  _we_dat_h
);

  localparam int              CTR_W = TASK_BITS + 3;
  localparam logic [CTR_W-1:0] LAST = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] ONE  = CTR_W'(1);

  state_t                  state;
  state_t                  state_nx;
  logic [CTR_W-1:0]        ctr;
  logic [CTR_W-1:0]        ctr_nx;
  logic [DAT_ADDR_W-1:0]   ctr_addr;
  logic [DAT_DATA_W-1:0]   ctr_pattern;

  logic                    busy_nx;
  logic                    done_nx;
  logic                    error_nx;
  logic [DAT_ADDR_W-1:0]   fail_addr_nx;
  logic [DAT_ADDR_W-1:0]   address_nx;
  logic [DAT_DATA_W-1:0]   wdata_nx;
  logic                    oe_nx;
  logic                    we_nx;

  assign ctr_addr    = DAT_ADDR_W'(ctr);
  assign ctr_pattern = identity_pattern(ctr[2:0]);

  // Next-state, counter, status and DAT port decode for the current state.
  always_comb begin
    state_nx     = state;
    ctr_nx       = ctr;
    error_nx     = error;
    fail_addr_nx = fail_addr;
    busy_nx      = 1'b1;
    done_nx      = 1'b0;
    address_nx   = {DAT_ADDR_W{1'b0}};
    wdata_nx     = {DAT_DATA_W{1'b0}};
    oe_nx        = 1'b0;
    we_nx        = 1'b1;
    case (state)
      W_SETUP: begin
        // Address/data settle one cycle ahead of the strobe.
        address_nx = ctr_addr;
        wdata_nx   = ctr_pattern;
        oe_nx      = 1'b1;
        state_nx   = W_STROBE;
      end
      W_STROBE: begin
        address_nx = ctr_addr;
        wdata_nx   = ctr_pattern;
        oe_nx      = 1'b1;
        we_nx      = 1'b0;
        if (ctr == LAST) begin
          // Phase change: counter restarts explicitly instead of wrapping.
          ctr_nx = {CTR_W{1'b0}};
          if (VERIFY) begin
            state_nx = V_ADDR;
          end else begin
            state_nx = DONE;
          end
        end else begin
          ctr_nx   = ctr + ONE;
          state_nx = W_SETUP;
        end
      end
      V_ADDR: begin
        address_nx = ctr_addr;
        state_nx   = V_CMP;
      end
      V_CMP: begin
        // Address is on the pins during this cycle; read data is compared here.
        address_nx = ctr_addr;
        if (dat_rdata != ctr_pattern) begin
          error_nx     = 1'b1;
          fail_addr_nx = ctr_addr;
          state_nx     = DONE;
        end else if (ctr == LAST) begin
          state_nx = DONE;
        end else begin
          ctr_nx   = ctr + ONE;
          state_nx = V_ADDR;
        end
      end
      DONE: begin
        busy_nx = 1'b0;
        done_nx = 1'b1;
        if (start) begin
          // Restart looks exactly like a reset cycle on the outputs.
          state_nx     = W_SETUP;
          ctr_nx       = {CTR_W{1'b0}};
          error_nx     = 1'b0;
          fail_addr_nx = {DAT_ADDR_W{1'b0}};
          busy_nx      = 1'b1;
          done_nx      = 1'b0;
        end else begin
          state_nx = DONE;
        end
      end
      default: begin
        state_nx = W_SETUP;
        ctr_nx   = {CTR_W{1'b0}};
      end
    endcase
  end

  // State, counter and registered outputs with synchronous active-low reset.
  always_ff @(posedge e) begin
    if (!_reset) begin
      state       <= W_SETUP;
      ctr         <= {CTR_W{1'b0}};
      busy        <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
      fail_addr   <= {DAT_ADDR_W{1'b0}};
      address_dat <= {DAT_ADDR_W{1'b0}};
      dat_wdata   <= {DAT_DATA_W{1'b0}};
      dat_oe      <= 1'b0;
      _we_dat_l   <= 1'b1;
      _we_dat_h   <= 1'b1;
    end else begin
      state       <= state_nx;
      ctr         <= ctr_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      error       <= error_nx;
      fail_addr   <= fail_addr_nx;
      address_dat <= address_nx;
      dat_wdata   <= wdata_nx;
      dat_oe      <= oe_nx;
      _we_dat_l   <= we_nx;
      _we_dat_h   <= we_nx;
    end
  end

endmodule
